// File: rtl/rs_drive_pkg.sv
// Shared state encoding and command codes for the RS drive sequencer.
package rs_drive_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ENABLE  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [1:0] CMD_HOLD    = 2'b00;
    localparam logic [1:0] CMD_SET     = 2'b01;
    localparam logic [1:0] CMD_RESET   = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

endpackage

// File: rtl/rs_fb_sync.sv
// Two-flop synchronizer bringing the flip-flop's Q/Q_comp into the clk domain.
// Only present when RS_FEEDBACK_CHECK_EN is defined.
`ifdef RS_FEEDBACK_CHECK_EN
module rs_fb_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] async_i,
    output logic [1:0] sync_o
);

    logic [1:0] meta_q;
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule
`endif

// File: rtl/rs_drive_sequencer.sv
// Sequences SET/RESET/HOLD commands into setup/enable/release R,S,enable waveforms; ready only in IDLE.
// RS_FEEDBACK_CHECK_EN adds synchronized Q/Q_comp feedback checking with a sticky fb_err.
module rs_drive_sequencer
    import rs_drive_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 2,
    parameter int unsigned REL_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       R,
    output logic       S,
    output logic       enable,
    output logic       busy,
    output logic       exp_q,
    output logic       cmd_err
`ifdef RS_FEEDBACK_CHECK_EN
    ,
    input  logic       q_fb,
    input  logic       qc_fb,
    output logic       fb_err
`endif
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LD   = CNT_W'(REL_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             r_q, r_d;
    logic             s_q, s_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    logic             expq_q, expq_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        r_d     = r_q;
        s_d     = s_q;
        expq_d  = expq_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    if (cmd == CMD_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                        cmd_d   = cmd;
                        s_d     = (cmd == CMD_SET);
                        r_d     = (cmd == CMD_RESET);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ENABLE;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ENABLE: begin
                if (cnt_q == '0) begin
                    state_d = RELEASE;
                    cnt_d   = REL_LD;
                    if (cmd_q == CMD_SET) begin
                        expq_d = 1'b1;
                    end else if (cmd_q == CMD_RESET) begin
                        expq_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    r_d     = 1'b0;
                    s_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered images of the next state.
        en_d   = (state_d == ENABLE);
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= CMD_HOLD;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            expq_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            r_q     <= r_d;
            s_q     <= s_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            expq_q  <= expq_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign R         = r_q;
    assign S         = s_q;
    assign enable    = en_q;
    assign busy      = busy_q;
    assign exp_q     = expq_q;
    assign cmd_err   = err_q;

`ifdef RS_FEEDBACK_CHECK_EN
    logic [1:0] fb_sync;
    logic       seen_q, seen_d;
    logic       fb_err_q, fb_err_d;
    logic       chk_pt;

    rs_fb_sync u_fb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i ({q_fb, qc_fb}),
        .sync_o  (fb_sync)
    );

    // HOLD leaves the latch untouched, so it is only checkable once a SET/RESET has defined it.
    assign chk_pt = (state_q == RELEASE) && (cnt_q == '0) && ((cmd_q != CMD_HOLD) || seen_q);

    always_comb begin
        seen_d   = seen_q;
        fb_err_d = fb_err_q;
        if (chk_pt) begin
            if ((fb_sync[1] != expq_q) || (fb_sync[1] == fb_sync[0])) begin
                fb_err_d = 1'b1;
            end
            if (cmd_q != CMD_HOLD) begin
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q   <= 1'b0;
            fb_err_q <= 1'b0;
        end else begin
            seen_q   <= seen_d;
            fb_err_q <= fb_err_d;
        end
    end

    assign fb_err = fb_err_q;
`endif

endmodule

// File: tb/tb_rs_drive_sequencer.sv
// Randomized + directed bench for rs_drive_sequencer against a cycles-since-accept reference model.
module tb_rs_drive_sequencer;

    localparam int SETUP = 2;
    localparam int EN    = 2;
    localparam int REL   = 1;
    localparam int TOTAL = SETUP + EN + REL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready, drv_r, drv_s, drv_en, busy, exp_q, cmd_err;

    int checks = 0;
    int errors = 0;

    // Reference model: k = cycles since accept (0 = idle).
    int         k;
    logic [1:0] m_cmd;
    logic       m_expq;
    logic       m_err;

    always #5 clk = ~clk;

`ifdef RS_FEEDBACK_CHECK_EN
    logic q_fb, qc_fb, fb_err;
    logic lq = 1'b0;
    int   fb_mode = 0;
    logic m_seen, m_fberr;

    always @* begin
        if (drv_en && drv_s) lq = 1'b1;
        else if (drv_en && drv_r) lq = 1'b0;
    end
    assign q_fb  = (fb_mode == 0) ? lq  : (fb_mode == 2);
    assign qc_fb = (fb_mode == 0) ? ~lq : (fb_mode == 1);
`endif

    rs_drive_sequencer #(
        .CNT_W(4), .SETUP_CYC(SETUP), .EN_CYC(EN), .REL_CYC(REL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .R         (drv_r),
        .S         (drv_s),
        .enable    (drv_en),
        .busy      (busy),
        .exp_q     (exp_q),
        .cmd_err   (cmd_err)
`ifdef RS_FEEDBACK_CHECK_EN
        ,
        .q_fb      (q_fb),
        .qc_fb     (qc_fb),
        .fb_err    (fb_err)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (!rst_n) begin
            k      = 0;
            m_expq = 1'b0;
            m_err  = 1'b0;
`ifdef RS_FEEDBACK_CHECK_EN
            m_seen  = 1'b0;
            m_fberr = 1'b0;
`endif
        end else if (k == 0) begin
            m_err = 1'b0;
            if (cmd_valid) begin
                if (cmd == 2'b11) m_err = 1'b1;
                else begin
                    k     = 1;
                    m_cmd = cmd;
                end
            end
        end else begin
            m_err = 1'b0;
`ifdef RS_FEEDBACK_CHECK_EN
            if (k == TOTAL && (m_cmd != 2'b00 || m_seen)) begin
                if (q_fb != m_expq || q_fb == qc_fb) m_fberr = 1'b1;
                if (m_cmd != 2'b00) m_seen = 1'b1;
            end
`endif
            k++;
            if (k == SETUP + EN + 1) begin
                if (m_cmd == 2'b01) m_expq = 1'b1;
                else if (m_cmd == 2'b10) m_expq = 1'b0;
            end
            if (k > TOTAL) k = 0;
        end
    endtask

    task automatic compare_all();
        check_val("R",         drv_r,     (k != 0) && (m_cmd == 2'b10));
        check_val("S",         drv_s,     (k != 0) && (m_cmd == 2'b01));
        check_val("enable",    drv_en,    (k >= SETUP + 1) && (k <= SETUP + EN));
        check_val("busy",      busy,      k != 0);
        check_val("cmd_ready", cmd_ready, k == 0);
        check_val("exp_q",     exp_q,     m_expq);
        check_val("cmd_err",   cmd_err,   m_err);
        check_val("r_and_s",   drv_r & drv_s, 1'b0);
`ifdef RS_FEEDBACK_CHECK_EN
        check_val("fb_err",    fb_err,    m_fberr);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [1:0] c);
        rst_n     = rst;
        cmd_valid = vld;
        cmd       = c;
    endtask

    initial begin
        k = 0; m_cmd = 2'b00; m_expq = 1'b0; m_err = 1'b0;
`ifdef RS_FEEDBACK_CHECK_EN
        m_seen = 1'b0; m_fberr = 1'b0;
`endif
        drive(1'b0, 1'b0, 2'b00);
        #1;
        // Reset for two cycles, then idle
        repeat (2) step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (3) step();

        // Single SET offered for one cycle
        drive(1'b1, 1'b1, 2'b01);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (7) step();

        // RESET with valid held across the whole sequence
        drive(1'b1, 1'b1, 2'b10);
        repeat (6) step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (3) step();

        // Illegal command in IDLE
        drive(1'b1, 1'b1, 2'b11);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (2) step();

        // Reset asserted during ENABLE of a SET
        drive(1'b1, 1'b1, 2'b01);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (3) step();
        check_val("mid_enable", drv_en, 1'b1);
        drive(1'b0, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (2) step();

`ifdef RS_FEEDBACK_CHECK_EN
        // Stuck Q=0/Qc=1 feedback against a SET must raise a sticky error
        fb_mode = 1;
        drive(1'b0, 1'b0, 2'b00);
        repeat (3) step();
        drive(1'b1, 1'b1, 2'b01);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (10) step();
        check_val("fb_stuck_bad", fb_err, 1'b1);
        fb_mode = 2;
        drive(1'b0, 1'b0, 2'b00);
        repeat (3) step();
        check_val("fb_cleared", fb_err, 1'b0);
        drive(1'b1, 1'b1, 2'b01);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (10) step();
        check_val("fb_stuck_good", fb_err, 1'b0);
        fb_mode = 0;
        drive(1'b0, 1'b0, 2'b00);
        repeat (3) step();
`endif

        // Randomized traffic with occasional resets at arbitrary phases
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst;
            logic       r_vld;
            logic [1:0] r_cmd;
            r_rst = ($urandom_range(0, 59) != 0);
            r_vld = ($urandom_range(0, 1) == 1);
            r_cmd = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            drive(r_rst, r_vld, r_cmd);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
